// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter sequencing states
//   gnt_t       : which requester owns (or last owned) the memory port
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    // Default widths of the core's address and data paths.
    localparam int unsigned MEM_ADDR_W_DEF = 32;
    localparam int unsigned MEM_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the IF-stage fetch
//   port and the MEM-stage load/store port. One access is in flight at a time;
//   the granted requester's address/we/wdata are captured on the grant edge and
//   held on mem_* until mem_ready. Read data is registered into if_rdata or
//   dm_rdata and flagged with a one-cycle done pulse.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_done)
//   if_rdata/if_done           registered fetch data + 1-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata                   load/store request (held until dm_done)
//   dm_rdata/dm_done           registered load data + 1-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                  registered memory request
//   mem_ready/mem_rdata        memory completion + read data
//   stall_if/stall_mem         req & ~done, to the hazard unit
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W_DEF,
    parameter int unsigned DATA_W = MEM_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        state_q,     state_d;
    gnt_t              last_gnt_q,  last_gnt_d;
    logic              abort_q,     abort_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              dm_done_q,   dm_done_d;

    gnt_t              pick;
    logic              live;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        abort_d     = abort_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        pick        = GNT_I;
        live        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Round-robin on a tie: the port that did not win last time.
                if (if_req && dm_req) begin
                    pick = (last_gnt_q == GNT_I) ? GNT_D : GNT_I;
                end else if (dm_req) begin
                    pick = GNT_D;
                end else begin
                    pick = GNT_I;
                end

                if (if_req || dm_req) begin
                    last_gnt_d = pick;
                    abort_d    = 1'b0;
                    mem_req_d  = 1'b1;
                    if (pick == GNT_D) begin
                        state_d     = S_GNT_D;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        state_d     = S_GNT_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                    end
                end
            end

            S_GNT_I: begin
                // A request dropped at any point during the grant (flush) makes
                // the access silent: it still completes on the bus, but no data
                // or done is returned to the fetch stage.
                live = if_req && !abort_q;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                    if (live) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    abort_d = !live;
                end
            end

            S_GNT_D: begin
                live = dm_req && !abort_q;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                    if (live) begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_done_d = 1'b1;
                    end
                end else begin
                    abort_d = !live;
                end
            end

            // The done pulse is already registered for this cycle; requests are
            // deliberately not sampled here so a requester that drops its
            // request in response to done is not served twice.
            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= GNT_I;
            abort_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            abort_q     <= abort_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;

    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = dm_req & ~dm_done_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Drives both requester ports against a small word-addressed memory device
//   with configurable latency and compares results with a transaction-level
//   reference model (round-robin order, memory contents, per-access bus data).
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    // ---------------- memory device + bus monitor ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic [31:0] mem_dev [64];
    logic [31:0] mem_ref [64];
    acc_t        grant_q [$];
    int unsigned grant_cnt = 0;
    bit          resp_en   = 1'b1;
    bit          rand_lat  = 1'b0;
    int unsigned lat_cfg   = 0;

    logic [31:0] last_if_fetch = '0;
    logic [31:0] last_dm_load  = '0;

    initial begin : responder
        int unsigned cnt;
        int unsigned lat_cur;
        logic        prev_req;
        cnt = 0; lat_cur = 0; prev_req = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom;   // junk unless this cycle completes a load
            if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                grant_cnt++;
                grant_q.push_back('{mem_we, mem_addr, mem_wdata});
                cnt     = 0;
                lat_cur = rand_lat ? $urandom_range(3, 0) : lat_cfg;
            end
            prev_req = mem_req;
            if (mem_req !== 1'b1) begin
                cnt = 0;
            end else if (resp_en) begin
                if (cnt >= lat_cur) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem_dev[mem_addr[7:2]] = mem_wdata;
                    else        mem_rdata = mem_dev[mem_addr[7:2]];
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All sampling and driving happens 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        if_addr  = 32'hFFFF_FFF0;
        dm_addr  = 32'h1234_5678;
        dm_wdata = 32'hFFFF_FFFF;
        dm_we    = 1'b1;
        do_reset();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({if_rdata, dm_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got if=%h dm=%h required 0", if_rdata, dm_rdata);
        end
        n_tests++;
        if ({if_done, dm_done, stall_if, stall_mem} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got done=%b%b stall=%b%b required 0000",
                     if_done, dm_done, stall_if, stall_mem);
        end
    endtask

    task automatic test_fetch_only();
        int          done_k;
        bit          dm_seen;
        int unsigned g0;
        g0 = grant_cnt; done_k = -1; dm_seen = 1'b0;
        rand_lat = 1'b0; lat_cfg = 2; resp_en = 1'b1;
        mem_dev[4] = 32'h0050_0093;
        dm_req = 1'b0; dm_we = 1'b1; dm_addr = 32'h44;
        if_addr = 32'h10; if_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_issue: got req=%b addr=%h we=%b required 1/00000010/0",
                             mem_req, mem_addr, mem_we);
                end
                n_tests++;
                if (stall_if !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fetch_stall: got %b required 1", stall_if);
                end
                if_addr = 32'h0000_0999;
            end
            if (k == 3) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
                    n_fail++;
                    $display("FAIL fetch_hold: got req=%b addr=%h required 1/00000010", mem_req, mem_addr);
                end
            end
            if (if_done === 1'b1 && done_k < 0) begin
                done_k = k;
                if_req = 1'b0;
            end
            if (dm_done === 1'b1) dm_seen = 1'b1;
        end
        if_req = 1'b0;
        n_tests++;
        if (done_k != 4) begin
            n_fail++;
            $display("FAIL fetch_latency: if_done at cycle %0d required 4", done_k);
        end
        n_tests++;
        if (if_rdata !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h required 00500093", if_rdata);
        end
        n_tests++;
        if (dm_seen || grant_cnt - g0 != 1) begin
            n_fail++;
            $display("FAIL fetch_single: dm_done=%b grants=%0d required 0/1", dm_seen, grant_cnt - g0);
        end
        last_if_fetch = 32'h0050_0093;
        tick();
    endtask

    task automatic test_simultaneous();
        int          order [$];
        int unsigned g0;
        do_reset();
        grant_q.delete(); g0 = grant_cnt;
        rand_lat = 1'b0; lat_cfg = 1; resp_en = 1'b1;
        mem_dev[0] = 32'hA5A5_0001;
        mem_dev[8] = 32'h1234_5678;
        if_addr = 32'h20; dm_addr = 32'h100; dm_we = 1'b0; dm_wdata = 32'h0;
        if_req = 1'b1; dm_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (if_done === 1'b1) begin order.push_back(0); if_req = 1'b0; end
            if (dm_done === 1'b1) begin order.push_back(1); dm_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        n_tests++;
        if (order.size() != 2 || order[0] != 1 || order[1] != 0) begin
            n_fail++;
            $display("FAIL tie_order: got %0d completions, first=%0d required 2 completions D(1) then I(0)",
                     order.size(), (order.size() > 0) ? order[0] : -1);
        end
        n_tests++;
        if (grant_cnt - g0 != 2 || grant_q.size() != 2 || grant_q[0].addr !== 32'h100) begin
            n_fail++;
            $display("FAIL tie_grants: got %0d grants required 2 with first addr 00000100", grant_cnt - g0);
        end
        n_tests++;
        if (dm_rdata !== 32'hA5A5_0001 || if_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL tie_rdata: got dm=%h if=%h required a5a50001/12345678", dm_rdata, if_rdata);
        end
        last_dm_load  = 32'hA5A5_0001;
        last_if_fetch = 32'h1234_5678;
        tick();
    endtask

    task automatic test_store();
        int done_k;
        done_k = -1;
        rand_lat = 1'b0; lat_cfg = 0; resp_en = 1'b1;
        dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h required 1/1/00000040/deadbeef",
                             mem_req, mem_we, mem_addr, mem_wdata);
                end
            end
            if (dm_done === 1'b1 && done_k < 0) begin
                done_k = k;
                dm_req = 1'b0;
            end
        end
        dm_req = 1'b0; dm_we = 1'b0;
        n_tests++;
        if (done_k != 2) begin
            n_fail++;
            $display("FAIL store_latency: dm_done at cycle %0d required 2", done_k);
        end
        n_tests++;
        if (dm_rdata !== last_dm_load || mem_dev[16] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_effect: got dm_rdata=%h mem=%h required %h/deadbeef",
                     dm_rdata, mem_dev[16], last_dm_load);
        end
        tick();
    endtask

    task automatic test_abort();
        bit          done_seen;
        bit          req_ok;
        int unsigned g0;
        g0 = grant_cnt; done_seen = 1'b0; req_ok = 1'b1;
        rand_lat = 1'b0; lat_cfg = 3; resp_en = 1'b1;
        mem_dev[12] = 32'hCAFE_F00D;
        if_addr = 32'h30; if_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) if_req = 1'b0;
            // Access issued in cycle 1, ready in cycle 4: request visible 1..4 only.
            if (k <= 4 && mem_req !== 1'b1) req_ok = 1'b0;
            if (k >= 5 && mem_req !== 1'b0) req_ok = 1'b0;
            if (if_done === 1'b1) done_seen = 1'b1;
        end
        n_tests++;
        if (!req_ok) begin
            n_fail++;
            $display("FAIL abort_bus: got mem_req profile wrong required high cycles 1..4 only");
        end
        n_tests++;
        if (done_seen || if_rdata !== last_if_fetch) begin
            n_fail++;
            $display("FAIL abort_resp: got if_done=%b if_rdata=%h required 0/%h",
                     done_seen, if_rdata, last_if_fetch);
        end
        n_tests++;
        if (grant_cnt - g0 != 1) begin
            n_fail++;
            $display("FAIL abort_grants: got %0d required 1", grant_cnt - g0);
        end
    endtask

    task automatic test_reset_mid();
        int done_k;
        bit stray;
        done_k = -1; stray = 1'b0;
        resp_en = 1'b0; rand_lat = 1'b0;
        dm_we = 1'b0; dm_addr = 32'h80; dm_req = 1'b1;
        tick();
        tick();
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_issue: got mem_req=%b required 1", mem_req);
        end
        reset = 1'b1; dm_req = 1'b0;
        tick();
        n_tests++;
        if (mem_req !== 1'b0 || dm_done !== 1'b0 || dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got req=%b done=%b dm_rdata=%h required 0/0/0",
                     mem_req, dm_done, dm_rdata);
        end
        reset = 1'b0; resp_en = 1'b1; lat_cfg = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (dm_done === 1'b1 || mem_req === 1'b1) stray = 1'b1;
        end
        n_tests++;
        if (stray) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got activity after reset required none");
        end
        mem_dev[32] = 32'h0BAD_C0DE;
        dm_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
                    n_fail++;
                    $display("FAIL rstmid_reissue: got req=%b addr=%h required 1/00000080", mem_req, mem_addr);
                end
            end
            if (dm_done === 1'b1 && done_k < 0) begin
                done_k = k;
                dm_req = 1'b0;
            end
        end
        dm_req = 1'b0;
        n_tests++;
        if (done_k != 3 || dm_rdata !== 32'h0BAD_C0DE) begin
            n_fail++;
            $display("FAIL rstmid_next: got done at %0d rdata=%h required 3/0badc0de", done_k, dm_rdata);
        end
        last_dm_load = 32'h0BAD_C0DE;
    endtask

    task automatic test_held_request();
        int          dones;
        int          drop_at;
        int unsigned g0;
        g0 = grant_cnt; dones = 0; drop_at = -1;
        rand_lat = 1'b0; lat_cfg = 1; resp_en = 1'b1;
        mem_dev[33] = 32'h1111_2222;
        dm_we = 1'b0; dm_addr = 32'h84; dm_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == drop_at) dm_req = 1'b0;
            if (dm_done === 1'b1) begin
                dones++;
                if (drop_at < 0) drop_at = k + 1;
            end
        end
        dm_req = 1'b0;
        n_tests++;
        if (grant_cnt - g0 != 1 || dones != 1) begin
            n_fail++;
            $display("FAIL held_req: got grants=%0d dones=%0d required 1/1", grant_cnt - g0, dones);
        end
        n_tests++;
        if (dm_rdata !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL held_rdata: got %h required 11112222", dm_rdata);
        end
        last_dm_load = 32'h1111_2222;
        tick();
    endtask

    // Transaction-level model: decide service order from the round-robin rule,
    // then replay the accesses in that order over a reference memory image.
    task automatic test_random();
        int          model_last;   // 0 = fetch, 1 = data
        int          ord [2];
        int          nreq;
        int          idx;
        int          p;
        logic [31:0] ia, da, dwd;
        logic        dwe;
        logic [31:0] exp_if, exp_dm;
        int unsigned g0;
        int          bad;

        do_reset();
        for (int i = 0; i < 64; i++) begin
            mem_dev[i] = $urandom;
            mem_ref[i] = mem_dev[i];
        end
        model_last = 0; exp_if = '0; exp_dm = '0;
        rand_lat = 1'b1; resp_en = 1'b1;

        for (int it = 0; it < 40; it++) begin
            p   = $urandom_range(2, 0);
            ia  = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            da  = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            dwe = 1'($urandom_range(1, 0));
            dwd = $urandom;
            if (p == 0)      begin nreq = 1; ord[0] = 0; end
            else if (p == 1) begin nreq = 1; ord[0] = 1; end
            else begin
                nreq = 2;
                ord[0] = (model_last == 0) ? 1 : 0;
                ord[1] = 1 - ord[0];
            end
            model_last = ord[nreq-1];

            for (int j = 0; j < nreq; j++) begin
                if (ord[j] == 0)  exp_if = mem_ref[ia[7:2]];
                else if (dwe)     mem_ref[da[7:2]] = dwd;
                else              exp_dm = mem_ref[da[7:2]];
            end

            grant_q.delete(); g0 = grant_cnt; idx = 0;
            if_addr = ia; dm_addr = da; dm_we = dwe; dm_wdata = dwd;
            if_req = (p != 1); dm_req = (p != 0);
            for (int k = 0; k < 40 && idx < nreq; k++) begin
                tick();
                if (if_done === 1'b1) begin
                    if_req = 1'b0;
                    n_tests++;
                    if (idx >= nreq || ord[idx] != 0 || if_rdata !== exp_if) begin
                        n_fail++;
                        $display("FAIL rnd_fetch it=%0d: got port I rdata=%h required port %0d rdata=%h",
                                 it, if_rdata, (idx < nreq) ? ord[idx] : -1, exp_if);
                    end
                    idx++;
                end
                if (dm_done === 1'b1) begin
                    dm_req = 1'b0;
                    n_tests++;
                    if (idx >= nreq || ord[idx] != 1 || dm_rdata !== exp_dm) begin
                        n_fail++;
                        $display("FAIL rnd_data it=%0d: got port D rdata=%h required port %0d rdata=%h",
                                 it, dm_rdata, (idx < nreq) ? ord[idx] : -1, exp_dm);
                    end
                    idx++;
                end
            end
            if_req = 1'b0; dm_req = 1'b0;
            n_tests++;
            if (idx != nreq) begin
                n_fail++;
                $display("FAIL rnd_timeout it=%0d: got %0d completions required %0d", it, idx, nreq);
            end
            tick();
            n_tests++;
            bad = 0;
            if (grant_cnt - g0 != nreq || grant_q.size() != nreq) bad = 1;
            else begin
                for (int j = 0; j < nreq; j++) begin
                    if (ord[j] == 0) begin
                        if (grant_q[j].we !== 1'b0 || grant_q[j].addr !== ia) bad = 1;
                    end else begin
                        if (grant_q[j].we !== dwe || grant_q[j].addr !== da) bad = 1;
                        if (dwe && grant_q[j].wdata !== dwd) bad = 1;
                    end
                end
            end
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd_bus it=%0d: got %0d accesses required %0d in model order with model fields",
                         it, grant_cnt - g0, nreq);
            end
            repeat ($urandom_range(2, 0)) tick();
        end

        n_tests++;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem_dev[i] !== mem_ref[i]) bad++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rnd_image: got %0d differing words required 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_abort();
        test_reset_mid();
        test_held_request();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
